keypad_entry: RTL and testbench

Hex keypad scanner and word assembler: the input-side counterpart of the seven-segment display path. It drives the row lines of a 4x4 matrix keypad and reads its column lines, debounces one key at a time, and emits each key as a hex digit. It shifts successive digits into a 32-bit word that the CPU top uses as operator-entered data. It sits in the board top beside the display instance and shares its clock.

---
 rtl/keypad_pkg.sv | 45 ++++
 rtl/keypad_tick.sv | 32 +++
 rtl/keypad_entry.sv | 184 ++++++++++++++++++
 tb/tb_keypad_entry.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared types and constants for the hex keypad scanner (keypad_entry).
//   - state_t     : scanner FSM states
//   - ROWS/COLS   : keypad matrix geometry
//   - DIGITS      : hex digits per assembled entry word
//   - *_IDX_W     : key_code field widths ({row_idx, col_idx})
//   - lowest_low  : index of the lowest-numbered low (pressed) column
//   - multi_low   : true when more than one column is low
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam int ROWS      = 4;
  localparam int COLS      = 4;
  localparam int DIGITS    = 8;
  localparam int ROW_IDX_W = 2;
  localparam int COL_IDX_W = 2;
  localparam int CODE_W    = ROW_IDX_W + COL_IDX_W;

  // Columns are active-low; scanning from the top down leaves the lowest
  // low index as the result.
  function automatic logic [COL_IDX_W-1:0] lowest_low(input logic [COLS-1:0] p);
    logic [COL_IDX_W-1:0] idx;
    idx = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!p[i]) idx = COL_IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic multi_low(input logic [COLS-1:0] p);
    int zeros;
    zeros = 0;
    for (int i = 0; i < COLS; i++) begin
      if (!p[i]) zeros++;
    end
    return (zeros > 1);
  endfunction

endpackage

// File: rtl/keypad_tick.sv
// keypad_tick
//   Scan-rate divider: counts 0..CLK_DIV-1 and pulses tick for one cycle
//   on the cycle the counter wraps.
//   Ports:
//     clk  in   system clock
//     rst  in   synchronous active-high reset (counter -> 0)
//     tick out  one-cycle pulse every CLK_DIV clocks
module keypad_tick #(
  parameter int CLK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_reg;

  assign tick = (cnt_reg == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry
//   4x4 hex keypad scanner, debouncer and 32-bit word assembler.
//   Rows are driven low one at a time; columns are sampled once per scan
//   tick. A debounced press emits key_code and shifts it into entry_data;
//   every 8th digit completes a word and pulses entry_valid.
//   Ports:
//     clk          in   system clock
//     rst          in   synchronous active-high reset
//     row[3:0]     out  row drive, active-low, one row low at a time
//     col[3:0]     in   column sense, active-low, asynchronous
//     key_valid    out  one-cycle pulse per accepted key
//     key_code[3:0]out  last accepted key {row_idx, col_idx}
//     entry_data   out  assembled word, newest digit in [3:0]
//     entry_valid  out  one-cycle pulse when a word's 8th digit is accepted
//   Build option:
//     KEYPAD_MULTI_REJECT_EN - when defined, a press pattern with more than
//     one low column is rejected instead of resolving to the lowest column.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int CLK_DIV        = 1000,
  parameter int DEBOUNCE_TICKS = 5
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [31:0] entry_data,
  output logic        entry_valid
);

  localparam int CNT_W   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int DIGIT_W = $clog2(DIGITS);
  localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(DIGITS - 1);

  logic                 tick;
  logic [COLS-1:0]      sync1_reg, sync2_reg;
  logic [COLS-1:0]      cs;
  state_t               state_reg, state_next;
  logic [ROW_IDX_W-1:0] row_idx_reg, row_idx_next;
  logic [COLS-1:0]      pattern_reg, pattern_next;
  logic [CNT_W-1:0]     stable_cnt_reg, stable_cnt_next;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 reached;
  logic                 reject;
  logic                 accept;
  logic [CODE_W-1:0]    code;
  logic                 key_valid_reg;
  logic [CODE_W-1:0]    key_code_reg;
  logic [31:0]          entry_data_reg;
  logic                 entry_valid_reg;
  logic [DIGIT_W-1:0]   digit_cnt_reg;
  logic                 word_done_reg;

  keypad_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchronizer; resets to the idle (all released) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
    end else begin
      sync1_reg <= col;
      sync2_reg <= sync1_reg;
    end
  end
  assign cs = sync2_reg;

  assign row     = ~(4'b0001 << row_idx_reg);
  assign cnt_inc = stable_cnt_reg + 1'b1;
  assign reached = (cnt_inc == CNT_W'(DEBOUNCE_TICKS));
  assign code    = {row_idx_reg, lowest_low(pattern_reg)};

`ifdef KEYPAD_MULTI_REJECT_EN
  assign reject = multi_low(pattern_reg);
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= SCAN;
      row_idx_reg    <= '0;
      pattern_reg    <= '1;
      stable_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      row_idx_reg    <= row_idx_next;
      pattern_reg    <= pattern_next;
      stable_cnt_reg <= stable_cnt_next;
    end
  end

  // All FSM decisions happen only on scan ticks; between ticks everything holds.
  always_comb begin
    state_next      = state_reg;
    row_idx_next    = row_idx_reg;
    pattern_next    = pattern_reg;
    stable_cnt_next = stable_cnt_reg;
    accept          = 1'b0;
    if (tick) begin
      case (state_reg)
        SCAN: begin
          if (cs == 4'hF) begin
            row_idx_next = row_idx_reg + 1'b1;
          end else begin
            // Row index stays frozen so the pressed row keeps being driven.
            pattern_next    = cs;
            stable_cnt_next = '0;
            state_next      = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (reject || (cs != pattern_reg)) begin
            state_next = SCAN;
          end else begin
            stable_cnt_next = cnt_inc;
            if (reached) begin
              accept     = 1'b1;
              state_next = HELD;
            end
          end
        end
        HELD: begin
          if (cs == 4'hF) begin
            stable_cnt_next = '0;
            state_next      = RELEASE;
          end
        end
        RELEASE: begin
          if (cs == 4'hF) begin
            stable_cnt_next = cnt_inc;
            if (reached) state_next = SCAN;
          end else begin
            state_next = HELD;
          end
        end
        default: state_next = SCAN;
      endcase
    end
  end

  // Output / word assembly registers, updated on the acceptance edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid_reg   <= 1'b0;
      key_code_reg    <= '0;
      entry_data_reg  <= '0;
      entry_valid_reg <= 1'b0;
      digit_cnt_reg   <= '0;
      word_done_reg   <= 1'b0;
    end else begin
      key_valid_reg   <= accept;
      entry_valid_reg <= accept && (digit_cnt_reg == LAST_DIGIT);
      if (accept) begin
        key_code_reg <= code;
        // The first digit after a completed word starts a fresh word.
        if ((digit_cnt_reg == '0) && word_done_reg) begin
          entry_data_reg <= {28'h0, code};
        end else begin
          entry_data_reg <= {entry_data_reg[27:0], code};
        end
        word_done_reg <= (digit_cnt_reg == LAST_DIGIT);
        if (digit_cnt_reg == LAST_DIGIT) begin
          digit_cnt_reg <= '0;
        end else begin
          digit_cnt_reg <= digit_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign key_valid   = key_valid_reg;
  assign key_code    = key_code_reg;
  assign entry_data  = entry_data_reg;
  assign entry_valid = entry_valid_reg;

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry
//   Directed bench for keypad_entry with CLK_DIV=4, DEBOUNCE_TICKS=3.
//   A behavioural keypad pulls the selected column mask low while the
//   pressed key's row is driven low. Expected values are hand-computed.
module tb_keypad_entry;

  localparam int CLK_DIV        = 4;
  localparam int DEBOUNCE_TICKS = 3;

  logic        clk;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] entry_data;
  logic        entry_valid;

  // keypad model
  logic        key_down;
  logic [1:0]  key_r;
  logic [3:0]  key_cols;

  int n_vec;
  int n_err;
  int kv_cnt;
  int ev_cnt;
  int ev_orphan;

  keypad_entry #(
    .CLK_DIV        (CLK_DIV),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row         (row),
    .col         (col),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .entry_data  (entry_data),
    .entry_valid (entry_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    col = 4'hF;
    if (key_down && (row[key_r] == 1'b0)) col = key_cols;
  end

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (key_valid) kv_cnt++;
    if (entry_valid) ev_cnt++;
    if (entry_valid && !key_valid) ev_orphan++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    key_down = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic press(input logic [1:0] r, input logic [3:0] cols, input int hold, input int rel);
    key_r    = r;
    key_cols = cols;
    key_down = 1'b1;
    step(hold);
    key_down = 1'b0;
    step(rel);
  endtask

  // Press a hex digit by value: row = d[3:2], column = d[1:0].
  task automatic press_digit(input logic [3:0] d);
    logic [3:0] m;
    m = ~(4'b0001 << d[1:0]);
    press(d[3:2], m, 40, 30);
  endtask

  // Wait until the scanner freshly moves onto the given row drive.
  task automatic wait_row_enter(input logic [3:0] target);
    int n;
    n = 0;
    while (row == target && n < 100) begin step(1); n++; end
    while (row != target && n < 100) begin step(1); n++; end
    if (n >= 100) check("row_wait", {28'h0, row}, {28'h0, target});
  endtask

  initial begin
    int kv0;
    logic [3:0] exp_row;
    logic [3:0] word_keys [8];
    n_vec = 0; n_err = 0; kv_cnt = 0; ev_cnt = 0; ev_orphan = 0;
    key_r = 2'd0; key_cols = 4'hF; key_down = 1'b0;

    // ---- reset state and row cycling ----
    do_reset();
    check("rst_row", {28'h0, row}, 32'h0000000E);
    check("rst_key_valid", {31'h0, key_valid}, 32'h0);
    check("rst_key_code", {28'h0, key_code}, 32'h0);
    check("rst_entry_data", entry_data, 32'h0);
    check("rst_entry_valid", {31'h0, entry_valid}, 32'h0);
    for (int i = 1; i < 4; i++) begin
      step(CLK_DIV);
      exp_row = ~(4'b0001 << i);
      check($sformatf("row_cycle%0d", i), {28'h0, row}, {28'h0, exp_row});
    end

    // ---- single key (2,1) ----
    do_reset();
    kv0 = kv_cnt;
    press(2'd2, 4'b1101, 40, 30);
    check("single_kv_count", kv_cnt - kv0, 32'd1);
    check("single_key_code", {28'h0, key_code}, 32'h9);
    check("single_entry_data", entry_data, 32'h00000009);

    // ---- bounce on key (0,0): low for 2 ticks only ----
    do_reset();
    kv0 = kv_cnt;
    wait_row_enter(4'b1110);
    press(2'd0, 4'b1110, 8, 0);
    step(20);
    check("bounce_kv_count", kv_cnt - kv0, 32'd0);
    wait_row_enter(4'b0111);
    check("bounce_row_resumes", {28'h0, row}, 32'h7);
    check("bounce_entry_data", entry_data, 32'h0);

    // ---- full word 1..8, then A ----
    do_reset();
    kv0 = kv_cnt;
    ev_cnt = 0; ev_orphan = 0;
    word_keys = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    for (int i = 0; i < 7; i++) press_digit(word_keys[i]);
    check("word_7_entry_data", entry_data, 32'h01234567);
    check("word_7_no_entry_valid", ev_cnt, 32'd0);
    press_digit(word_keys[7]);
    check("word_entry_data", entry_data, 32'h12345678);
    check("word_entry_valid_count", ev_cnt, 32'd1);
    check("word_entry_valid_with_key", ev_orphan, 32'd0);
    check("word_kv_count", kv_cnt - kv0, 32'd8);
    press_digit(4'hA);
    check("word_next_entry_data", entry_data, 32'h0000000A);
    check("word_next_no_entry_valid", ev_cnt, 32'd1);

    // ---- multi-press: cols 1 and 3 on row 0, held long ----
    do_reset();
    kv0 = kv_cnt;
    press(2'd0, 4'b0101, 100, 30);
`ifdef KEYPAD_MULTI_REJECT_EN
    check("multi_kv_count", kv_cnt - kv0, 32'd0);
    check("multi_entry_data", entry_data, 32'h0);
`else
    check("multi_kv_count", kv_cnt - kv0, 32'd1);
    check("multi_key_code", {28'h0, key_code}, 32'h1);
`endif

    // ---- reset during debounce of key 5 after 3 digits ----
    do_reset();
    press_digit(4'h1);
    press_digit(4'h2);
    press_digit(4'h3);
    check("midrst_partial", entry_data, 32'h00000123);
    kv0 = kv_cnt;
    wait_row_enter(4'b1101);
    key_r = 2'd1; key_cols = 4'b1101; key_down = 1'b1;
    step(6);
    do_reset();
    check("midrst_entry_data", entry_data, 32'h0);
    step(30);
    check("midrst_kv_count", kv_cnt - kv0, 32'd0);
    press_digit(4'h7);
    check("midrst_next_entry_data", entry_data, 32'h00000007);
    check("midrst_next_key_code", {28'h0, key_code}, 32'h7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
